osd_stm_trace_tap: RTL and testbench
====================================

OSD_STM_TRACE_TAP -- requirements
Module: osd_stm_trace_tap

Interface
REQ-001 Parameter XLEN, default 32, meaning core register width; legal values 32 and 64.
REQ-002 Parameter VALUE_REG, default 3, meaning GPR index whose content is traced as the value.
REQ-003 Parameter MARKER_OPC, default 32'h1500_0000, meaning marker instruction encoding (upper 16 bits compared, lower 16 = trace id).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  trace capture enable (quasi-static).
REQ-008 retire_valid  input  1  one instruction retires this cycle.
REQ-009 retire_insn  input  32  encoding of the retiring instruction.
REQ-010 wb_valid  input  1  GPR writeback this cycle.
REQ-011 wb_reg  input  5  writeback destination index.
REQ-012 wb_data  input  XLEN  writeback data.
REQ-013 trace_valid  output  1  one-cycle event strobe to osd_stm.
REQ-014 trace_id  output  16  event id.
REQ-015 trace_value  output  64  event value, zero-extended from XLEN.
REQ-016 event_count  output  16  events emitted since reset, wraps.
REQ-017 drop_count  output  16  markers suppressed while disabled, saturates.

Function
REQ-018 A shadow register SHALL load wb_data on every cycle with wb_valid=1 and wb_reg=VALUE_REG.
REQ-019 A marker SHALL be retire_valid=1 with retire_insn[31:16]=MARKER_OPC[31:16] and retire_insn[15:0]!=0; id 0 SHALL never be traced.
REQ-020 On a marker with enable=1, the block SHALL assert trace_valid exactly one cycle later, with trace_id=retire_insn[15:0].
REQ-021 trace_value SHALL be the shadow value; if a VALUE_REG writeback coincides with the marker cycle, wb_data SHALL be used (forwarding).
REQ-022 Writebacks to any other register, or with wb_valid=0, SHALL not alter the shadow.
REQ-023 trace_id and trace_value SHALL hold their last values while trace_valid=0.
REQ-024 Back-to-back markers on consecutive cycles SHALL produce back-to-back strobes; no event is lost, and no backpressure exists.
REQ-025 event_count SHALL increment by one per trace_valid and wrap from 16'hFFFF to 0.
REQ-026 A marker with enable=0 SHALL produce no strobe; drop_count SHALL increment and saturate at 16'hFFFF.
REQ-027 enable is sampled in the marker cycle; changes in other cycles SHALL not affect that event.
REQ-028 For XLEN=32, trace_value[63:32] SHALL be 0.

Reset
REQ-029 While rst_n=0, trace_valid, trace_id, trace_value, event_count, drop_count and the shadow SHALL be 0.
REQ-030 A marker retiring in the cycle rst_n deasserts SHALL be ignored; any strobe in flight at reset assertion SHALL be discarded immediately.

Structure
REQ-031 The default marker opcode and the 64-bit trace value width SHALL be defined as constants in the shared OSD package.
REQ-032 The block SHALL be flat with no sub-module; osd_stm consumes trace_valid/trace_id/trace_value directly.

Verification
REQ-033 Marker test: wb r3=32'hDEAD_BEEF, then retire 32'h1500_0042 -> one cycle later trace_valid=1, id=16'h0042, value=64'h0000_0000_DEAD_BEEF, event_count=1.
REQ-034 Forwarding test: retire 32'h1500_0007 while wb r3=32'h1234_5678 in the same cycle -> value=64'h1234_5678; a same-cycle wb to r4 does not alter the value.
REQ-035 Filter test: retire 32'h1500_0000 and 32'h1501_0005 -> no strobe; both counters stay unchanged.
REQ-036 Burst test: three markers (ids 1, 2, 3) on consecutive cycles -> three consecutive strobes with ids 1, 2, 3; event_count=3. A separate run preloads event_count to 16'hFFFF and sends one more marker -> event_count wraps to 0.
REQ-037 Disable/saturation test: enable=0, then 70000 markers -> no strobes; drop_count=16'hFFFF.
REQ-038 Reset test: assert rst_n=0 in the cycle after a marker -> trace_valid=0 immediately and all outputs read 0.

Source files
------------

// File: rtl/osd_stm_trace_tap_pkg.sv
// Shared OSD constants used by the STM trace tap and its consumers.
package osd_stm_trace_tap_pkg;

    localparam logic [31:0] OSD_MARKER_OPC    = 32'h1500_0000;
    localparam int          OSD_TRACE_VALUE_W = 64;
    localparam int          OSD_TRACE_ID_W    = 16;
    localparam int          OSD_COUNT_W       = 16;

endpackage

// File: rtl/osd_stm_trace_tap.sv
// Watches retiring instructions for marker encodings and emits one-cycle
// trace events (id + shadowed GPR value) towards osd_stm.
module osd_stm_trace_tap
    import osd_stm_trace_tap_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          VALUE_REG  = 3,
    parameter logic [31:0] MARKER_OPC = OSD_MARKER_OPC
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         retire_valid,
    input  logic [31:0]                  retire_insn,
    input  logic                         wb_valid,
    input  logic [4:0]                   wb_reg,
    input  logic [XLEN-1:0]              wb_data,
    output logic                         trace_valid,
    output logic [OSD_TRACE_ID_W-1:0]    trace_id,
    output logic [OSD_TRACE_VALUE_W-1:0] trace_value,
    output logic [OSD_COUNT_W-1:0]       event_count,
    output logic [OSD_COUNT_W-1:0]       drop_count
);

    localparam logic [4:0] VALUE_REG_IDX = VALUE_REG[4:0];

    logic [XLEN-1:0] shadow_q;
    logic            armed_q;
    logic            value_wb;
    logic            is_marker;
    logic [XLEN-1:0] cur_value;

    assign value_wb  = wb_valid && (wb_reg == VALUE_REG_IDX);
    assign cur_value = value_wb ? wb_data : shadow_q;

    // armed_q stays low for the first edge after reset release, so a marker
    // retiring right as reset lifts is ignored.
    assign is_marker = armed_q && retire_valid &&
                       (retire_insn[31:16] == MARKER_OPC[31:16]) &&
                       (retire_insn[15:0] != 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            shadow_q <= '0;
        end else begin
            armed_q <= 1'b1;
            if (value_wb) begin
                shadow_q <= wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid <= 1'b0;
            trace_id    <= '0;
            trace_value <= '0;
            event_count <= '0;
            drop_count  <= '0;
        end else begin
            trace_valid <= is_marker && enable;
            if (is_marker && enable) begin
                trace_id    <= retire_insn[15:0];
                trace_value <= OSD_TRACE_VALUE_W'(cur_value);
                event_count <= event_count + 16'd1;
            end
            if (is_marker && !enable && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_osd_stm_trace_tap.sv
// Directed self-checking bench for osd_stm_trace_tap (default parameters).
module tb_osd_stm_trace_tap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        retire_valid;
    logic [31:0] retire_insn;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        trace_valid;
    logic [15:0] trace_id;
    logic [63:0] trace_value;
    logic [15:0] event_count;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    osd_stm_trace_tap dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .retire_valid (retire_valid),
        .retire_insn  (retire_insn),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .trace_valid  (trace_valid),
        .trace_id     (trace_id),
        .trace_value  (trace_value),
        .event_count  (event_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        retire_valid = 1'b0;
        retire_insn  = 32'h0;
        wb_valid     = 1'b0;
        wb_reg       = 5'd0;
        wb_data      = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        total++; if (trace_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", trace_valid); end
        total++; if (trace_id !== 16'h0) begin bad++; $display("[TB] FAIL reset_id got=%h exp=0000", trace_id); end
        total++; if (trace_value !== 64'h0) begin bad++; $display("[TB] FAIL reset_value got=%h exp=0", trace_value); end
        total++; if (event_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_event got=%h exp=0000", event_count); end
        total++; if (drop_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_drop got=%h exp=0000", drop_count); end
        // marker retiring in the deassertion cycle must be ignored
        rst_n        = 1'b1;
        retire_valid = 1'b1;
        retire_insn  = 32'h1500_0042;
        @(negedge clk);
        clear_inputs();
        total++; if (trace_valid !== 1'b0) begin bad++; $display("[TB] FAIL deassert_marker_valid got=%0b exp=0", trace_valid); end
        total++; if (event_count !== 16'h0) begin bad++; $display("[TB] FAIL deassert_marker_event got=%h exp=0000", event_count); end
    endtask

    task automatic test_marker();
        wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_inputs();
        retire_valid = 1'b1; retire_insn = 32'h1500_0042;
        @(negedge clk);
        clear_inputs();
        total++; if (trace_valid !== 1'b1) begin bad++; $display("[TB] FAIL marker_valid got=%0b exp=1", trace_valid); end
        total++; if (trace_id !== 16'h0042) begin bad++; $display("[TB] FAIL marker_id got=%h exp=0042", trace_id); end
        total++; if (trace_value !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("[TB] FAIL marker_value got=%h exp=00000000deadbeef", trace_value); end
        total++; if (event_count !== 16'd1) begin bad++; $display("[TB] FAIL marker_event got=%0d exp=1", event_count); end
        @(negedge clk);
        total++; if (trace_valid !== 1'b0) begin bad++; $display("[TB] FAIL marker_oneshot got=%0b exp=0", trace_valid); end
        total++; if (trace_id !== 16'h0042 || trace_value !== 64'hDEAD_BEEF) begin bad++; $display("[TB] FAIL marker_hold got=%h/%h exp=0042/deadbeef", trace_id, trace_value); end
    endtask

    task automatic test_forwarding();
        retire_valid = 1'b1; retire_insn = 32'h1500_0007;
        wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h1234_5678;
        @(negedge clk);
        total++; if (trace_id !== 16'h0007 || trace_value !== 64'h1234_5678) begin bad++; $display("[TB] FAIL fwd_r3 got=%h/%h exp=0007/12345678", trace_id, trace_value); end
        retire_insn = 32'h1500_0008;
        wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'hAAAA_5555;
        @(negedge clk);
        total++; if (trace_id !== 16'h0008 || trace_value !== 64'h1234_5678) begin bad++; $display("[TB] FAIL fwd_other_reg got=%h/%h exp=0008/12345678", trace_id, trace_value); end
        retire_insn = 32'h1500_0009;
        wb_valid = 1'b0; wb_reg = 5'd3; wb_data = 32'hFFFF_0000;
        @(negedge clk);
        clear_inputs();
        total++; if (trace_id !== 16'h0009 || trace_value !== 64'h1234_5678) begin bad++; $display("[TB] FAIL fwd_no_valid got=%h/%h exp=0009/12345678", trace_id, trace_value); end
        total++; if (event_count !== 16'd4) begin bad++; $display("[TB] FAIL fwd_event got=%0d exp=4", event_count); end
    endtask

    task automatic test_filter();
        retire_valid = 1'b1; retire_insn = 32'h1500_0000;
        @(negedge clk);
        total++; if (trace_valid !== 1'b0) begin bad++; $display("[TB] FAIL filter_id0 got=%0b exp=0", trace_valid); end
        retire_insn = 32'h1501_0005;
        @(negedge clk);
        clear_inputs();
        total++; if (trace_valid !== 1'b0) begin bad++; $display("[TB] FAIL filter_opc got=%0b exp=0", trace_valid); end
        @(negedge clk);
        total++; if (event_count !== 16'd4 || drop_count !== 16'd0) begin bad++; $display("[TB] FAIL filter_counts got=%0d/%0d exp=4/0", event_count, drop_count); end
    endtask

    task automatic test_enable_sampling();
        enable = 1'b1;
        retire_valid = 1'b1; retire_insn = 32'h1500_0011;
        @(negedge clk);
        clear_inputs();
        enable = 1'b0;
        total++; if (trace_valid !== 1'b1 || trace_id !== 16'h0011) begin bad++; $display("[TB] FAIL en_late_drop got=%0b/%h exp=1/0011", trace_valid, trace_id); end
        retire_valid = 1'b1; retire_insn = 32'h1500_0012;
        @(negedge clk);
        clear_inputs();
        enable = 1'b1;
        total++; if (trace_valid !== 1'b0 || drop_count !== 16'd1) begin bad++; $display("[TB] FAIL en_disabled_marker got=%0b/%0d exp=0/1", trace_valid, drop_count); end
        @(negedge clk);
        total++; if (trace_valid !== 1'b0 || trace_id !== 16'h0011 || event_count !== 16'd5) begin bad++; $display("[TB] FAIL en_late_raise got=%0b/%h/%0d exp=0/0011/5", trace_valid, trace_id, event_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1;
        retire_valid = 1'b1; retire_insn = 32'h1500_0001;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total++;
            if (trace_valid !== 1'b1 || trace_id !== 16'(i) || trace_value !== 64'h0) begin
                bad++; $display("[TB] FAIL burst_%0d got=%0b/%h/%h exp=1/%h/0", i, trace_valid, trace_id, trace_value, 16'(i));
            end
            if (i < 3) retire_insn = {16'h1500, 16'(i + 1)};
            else clear_inputs();
        end
        @(negedge clk);
        total++; if (trace_valid !== 1'b0 || event_count !== 16'd3) begin bad++; $display("[TB] FAIL burst_end got=%0b/%0d exp=0/3", trace_valid, event_count); end
    endtask

    task automatic test_wrap();
        force dut.event_count = 16'hFFFF;
        retire_valid = 1'b1; retire_insn = 32'h1500_0077;
        #1 release dut.event_count;
        @(negedge clk);
        clear_inputs();
        total++; if (trace_valid !== 1'b1 || event_count !== 16'h0000) begin bad++; $display("[TB] FAIL wrap got=%0b/%h exp=1/0000", trace_valid, event_count); end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        retire_valid = 1'b1; retire_insn = 32'h1500_0055;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        total++; if (trace_valid !== 1'b0) begin bad++; $display("[TB] FAIL inflight_valid got=%0b exp=0", trace_valid); end
        total++; if (trace_id !== 16'h0 || trace_value !== 64'h0 || event_count !== 16'h0 || drop_count !== 16'h0) begin
            bad++; $display("[TB] FAIL inflight_outputs got=%h/%h/%h/%h exp=0/0/0/0", trace_id, trace_value, event_count, drop_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_disable();
        int strobes = 0;
        enable = 1'b0;
        retire_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            retire_insn = {16'h1500, 16'((i % 65535) + 1)};
            @(negedge clk);
            if (trace_valid) strobes++;
            if (i == 999) begin
                total++; if (drop_count !== 16'd1000) begin bad++; $display("[TB] FAIL drop_partial got=%0d exp=1000", drop_count); end
            end
        end
        clear_inputs();
        @(negedge clk);
        if (trace_valid) strobes++;
        total++; if (strobes != 0) begin bad++; $display("[TB] FAIL disabled_strobes got=%0d exp=0", strobes); end
        total++; if (drop_count !== 16'hFFFF) begin bad++; $display("[TB] FAIL drop_saturate got=%h exp=ffff", drop_count); end
        total++; if (event_count !== 16'h0) begin bad++; $display("[TB] FAIL disabled_event got=%h exp=0000", event_count); end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_marker();
        test_forwarding();
        test_filter();
        test_enable_sampling();
        test_back_to_back();
        test_wrap();
        test_reset_inflight();
        test_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
